// File: rtl/ppu_pkg.sv
// Shared types for the PPU VRAM arbiter: cycle-type FSM states, read owner tags, rw codes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ppu_pkg;

  // Type of the VRAM cycle currently on the vram_* bus
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RND_ACC = 2'd1,
    ST_CPU_RD  = 2'd2,
    ST_CPU_WR  = 2'd3
  } vram_state_e;

  // Who receives the data of a VRAM read
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RND  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/ppu_nt_mirror.sv
// Folds the 4 KiB nametable space onto the 2 KiB VRAM according to the mirroring mode.
// Latency: combinational.
// Backpressure: not applicable.
module ppu_nt_mirror (
  input  logic [11:0] addr,
  input  logic        mirror_vert,
  output logic [10:0] vram_addr
);

  // Vertical mirroring keeps A10 (left/right tables), horizontal keeps A11 (top/bottom)
  assign vram_addr = {(mirror_vert ? addr[10] : addr[11]), addr[9:0]};

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Arbitrates renderer and CPU (PPUDATA) accesses onto one single-port VRAM, renderer first.
// Latency: renderer accept -> vram_* 1 cycle -> rvalid 2 cycles; CPU buffered one entry, then same.
// Backpressure: cpu_ready = buffer empty or being granted; rnd_ready drops for one cycle to force a starved CPU grant.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mirror_vert,
  input  logic        rnd_valid,
  output logic        rnd_ready,
  input  logic [11:0] rnd_addr,
  output logic [7:0]  rnd_rdata,
  output logic        rnd_rvalid,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_rw,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic [10:0] vram_addr,
  output logic [7:0]  vram_data_out,
  output logic        vram_en,
  output logic        vram_rw,
  input  logic [7:0]  vram_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic              buf_vld_q;
  logic              buf_rw_q;
  logic [11:0]       buf_addr_q;
  logic [7:0]        buf_wdata_q;
  logic [CW-1:0]     starve_q, starve_d;
  vram_state_e       state_q, state_d;
  owner_e            rd_owner_q;
  logic [10:0]       vram_addr_q;
  logic [7:0]        vram_data_q;
  logic              vram_rw_q;
  logic [7:0]        rnd_hold_q;
  logic [7:0]        cpu_hold_q;

  logic              force_cpu;
  logic              rnd_acc;
  logic              cpu_gnt;
  logic              cpu_cap;
  logic [11:0]       gnt_addr;
  logic [10:0]       gnt_vaddr;

  // A CPU entry that has lost STARVE_LIMIT times blocks the renderer for one cycle
  assign force_cpu = buf_vld_q && (starve_q == CW'(STARVE_LIMIT));
  assign rnd_ready = !force_cpu;
  assign rnd_acc   = rnd_valid && rnd_ready;
  assign cpu_gnt   = buf_vld_q && !rnd_acc;
  assign cpu_ready = !buf_vld_q || cpu_gnt;
  assign cpu_cap   = cpu_valid && cpu_ready;

  // Only one address reaches the mirror: the winner of this cycle
  assign gnt_addr = rnd_acc ? rnd_addr : buf_addr_q;

  ppu_nt_mirror u_mirror (
    .addr        (gnt_addr),
    .mirror_vert (mirror_vert),
    .vram_addr   (gnt_vaddr)
  );

  // Next VRAM cycle type and saturating refusal count of the buffered CPU entry
  always_comb begin
    state_d  = ST_IDLE;
    starve_d = starve_q;
    if (rnd_acc) begin
      state_d = ST_RND_ACC;
    end else if (cpu_gnt) begin
      state_d = (buf_rw_q == RW_READ) ? ST_CPU_RD : ST_CPU_WR;
    end
    if (cpu_gnt) begin
      starve_d = '0;
    end else if (buf_vld_q && (starve_q != CW'(STARVE_LIMIT))) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // FSM state and starvation counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // One-entry CPU buffer: a grant and a new capture may happen on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_q   <= 1'b0;
      buf_rw_q    <= RW_READ;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
    end else if (cpu_cap) begin
      buf_vld_q   <= 1'b1;
      buf_rw_q    <= cpu_rw;
      buf_addr_q  <= cpu_addr;
      buf_wdata_q <= cpu_wdata;
    end else if (cpu_gnt) begin
      buf_vld_q   <= 1'b0;
    end
  end

  // VRAM bus registers; they keep their last value on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr_q <= '0;
      vram_data_q <= '0;
      vram_rw_q   <= RW_READ;
    end else if (state_d != ST_IDLE) begin
      vram_addr_q <= gnt_vaddr;
      vram_rw_q   <= (state_d == ST_CPU_WR) ? RW_WRITE : RW_READ;
      if (state_d == ST_CPU_WR) begin
        vram_data_q <= buf_wdata_q;
      end
    end
  end

  // Tag the read on the bus now so its data, arriving next cycle, goes to the right owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      case (state_q)
        ST_RND_ACC: rd_owner_q <= OWN_RND;
        ST_CPU_RD:  rd_owner_q <= OWN_CPU;
        default:    rd_owner_q <= OWN_NONE;
      endcase
    end
  end

  // Remember the last returned byte per owner so rdata holds between returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_hold_q <= '0;
      cpu_hold_q <= '0;
    end else begin
      if (rd_owner_q == OWN_RND) rnd_hold_q <= vram_rdata;
      if (rd_owner_q == OWN_CPU) cpu_hold_q <= vram_rdata;
    end
  end

  assign vram_en       = (state_q != ST_IDLE);
  assign vram_addr     = vram_addr_q;
  assign vram_data_out = vram_data_q;
  assign vram_rw       = vram_rw_q;

  assign rnd_rvalid = (rd_owner_q == OWN_RND);
  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign rnd_rdata  = rnd_rvalid ? vram_rdata : rnd_hold_q;
  assign cpu_rdata  = cpu_rvalid ? vram_rdata : cpu_hold_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: not applicable.
// Backpressure: requesters hold valid/addr/data until the model says the request was taken.
module tb_ppu_vram_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mirror_vert;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [11:0] rnd_addr;
  logic [7:0]  rnd_rdata;
  logic        rnd_rvalid;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_rw;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [10:0] vram_addr;
  logic [7:0]  vram_data_out;
  logic        vram_en;
  logic        vram_rw;
  logic [7:0]  vram_rdata = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  ppu_vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mirror_vert   (mirror_vert),
    .rnd_valid     (rnd_valid),
    .rnd_ready     (rnd_ready),
    .rnd_addr      (rnd_addr),
    .rnd_rdata     (rnd_rdata),
    .rnd_rvalid    (rnd_rvalid),
    .cpu_valid     (cpu_valid),
    .cpu_ready     (cpu_ready),
    .cpu_rw        (cpu_rw),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_rvalid    (cpu_rvalid),
    .vram_addr     (vram_addr),
    .vram_data_out (vram_data_out),
    .vram_en       (vram_en),
    .vram_rw       (vram_rw),
    .vram_rdata    (vram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous 2 KiB VRAM macro: read data one cycle after the enabled cycle
  logic [7:0] ram [2048];
  always @(posedge clk) begin
    if (vram_en) begin
      if (vram_rw) vram_rdata <= ram[vram_addr];
      else         ram[vram_addr] <= vram_data_out;
    end
  end

  function automatic logic [7:0] init_byte(int i);
    return 8'(i * 7 + 3);
  endfunction

  // Nametable folding written as plain arithmetic on 1 KiB pages
  function automatic int mir(int a, bit v);
    return (a % 1024) + 1024 * (v ? ((a / 1024) % 2) : (a / 2048));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_buf_vld   = 0;
  bit m_buf_rw    = 1;
  int m_buf_addr  = 0;
  int m_buf_wdata = 0;
  int m_refused   = 0;
  bit e_en        = 0;
  bit e_rw        = 1;
  int e_addr      = 0;
  int e_wdata     = 0;
  int e_owner     = 0;
  int p_owner     = 0;
  int p_data      = 0;
  int e_rnd_rdata = 0;
  int e_cpu_rdata = 0;
  bit m_rnd_taken = 0;
  bit m_cpu_taken = 0;
  bit m_rdy, m_racc, m_cgnt, m_crdy;
  int shadow [2048];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_buf_vld = 0; m_refused = 0;
      e_en = 0; e_rw = 1; e_addr = 0; e_wdata = 0;
      p_owner = 0; e_rnd_rdata = 0; e_cpu_rdata = 0;
      m_rnd_taken = 0; m_cpu_taken = 0;
    end else begin
      m_rdy  = !(m_buf_vld && m_refused >= LIMIT);
      m_racc = rnd_valid && m_rdy;
      m_cgnt = m_buf_vld && !m_racc;
      m_crdy = !m_buf_vld || m_cgnt;
      // the access on the bus during the cycle just ended completes now
      p_owner = 0;
      if (e_en) begin
        if (e_rw) begin
          p_owner = e_owner;
          p_data  = shadow[e_addr];
        end else begin
          shadow[e_addr] = e_wdata;
        end
      end
      if (p_owner == 1) e_rnd_rdata = p_data;
      if (p_owner == 2) e_cpu_rdata = p_data;
      // the access granted at this edge appears on the bus next
      e_en = 0;
      if (m_racc) begin
        e_en = 1; e_rw = 1; e_owner = 1;
        e_addr = mir(int'(rnd_addr), mirror_vert);
      end else if (m_cgnt) begin
        e_en = 1; e_rw = m_buf_rw; e_owner = 2;
        e_addr = mir(m_buf_addr, mirror_vert);
        if (!m_buf_rw) e_wdata = m_buf_wdata;
      end
      if (m_cgnt) m_refused = 0;
      else if (m_buf_vld && m_refused < LIMIT) m_refused++;
      if (m_cgnt) m_buf_vld = 0;
      m_cpu_taken = cpu_valid && m_crdy;
      if (m_cpu_taken) begin
        m_buf_vld = 1; m_buf_rw = cpu_rw;
        m_buf_addr = int'(cpu_addr); m_buf_wdata = int'(cpu_wdata);
      end
      m_rnd_taken = m_racc;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  bit x_rnd_ready, x_cpu_ready;
  always @(negedge clk) begin
    x_rnd_ready = !(m_buf_vld && m_refused >= LIMIT);
    x_cpu_ready = !m_buf_vld || !(rnd_valid && x_rnd_ready);
    check("rnd_ready", 32'(rnd_ready), 32'(x_rnd_ready));
    check("cpu_ready", 32'(cpu_ready), 32'(x_cpu_ready));
    check("vram_en", 32'(vram_en), 32'(e_en));
    check("vram_rw", 32'(vram_rw), 32'(e_rw));
    check("vram_addr", 32'(vram_addr), 32'(e_addr));
    check("vram_data_out", 32'(vram_data_out), 32'(e_wdata));
    check("rnd_rvalid", 32'(rnd_rvalid), 32'(p_owner == 1));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(p_owner == 2));
    check("rnd_rdata", 32'(rnd_rdata), 32'(e_rnd_rdata));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_vram_en"}, 32'(vram_en), 32'd0);
    check({tag, "_vram_rw"}, 32'(vram_rw), 32'd1);
    check({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
    check({tag, "_vram_data"}, 32'(vram_data_out), 32'd0);
    check({tag, "_rnd_rvalid"}, 32'(rnd_rvalid), 32'd0);
    check({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    check({tag, "_rnd_rdata"}, 32'(rnd_rdata), 32'd0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd1);
    check({tag, "_rnd_ready"}, 32'(rnd_ready), 32'd1);
  endtask

  task automatic rand_drive(input int p_rnd, input int p_cpu);
    if (!(rnd_valid && !m_rnd_taken)) begin
      rnd_valid = ($urandom_range(0, 99) < p_rnd);
      rnd_addr  = 12'($urandom);
    end
    if (!(cpu_valid && !m_cpu_taken)) begin
      cpu_valid = ($urandom_range(0, 99) < p_cpu);
      cpu_rw    = 1'($urandom_range(0, 1));
      cpu_addr  = 12'($urandom);
      cpu_wdata = 8'($urandom);
    end
    mirror_vert = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]    = init_byte(i);
      shadow[i] = int'(init_byte(i));
    end
    rst_n = 1'b1;
    mirror_vert = 1'b1; rnd_valid = 1'b0; rnd_addr = '0;
    cpu_valid = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    #1 rst_n = 1'b0;
    #1 reset_checks("reset");
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // CPU write $0155 = 0x55, vertical mirroring
    mirror_vert = 1'b1; cpu_valid = 1'b1; cpu_rw = 1'b0;
    cpu_addr = 12'h155; cpu_wdata = 8'h55;
    cyc();
    cpu_valid = 1'b0;
    cyc();
    check("wr155_en", 32'(vram_en), 32'd1);
    check("wr155_rw", 32'(vram_rw), 32'd0);
    check("wr155_addr", 32'(vram_addr), 32'h155);
    check("wr155_data", 32'(vram_data_out), 32'h55);
    cyc();
    check("wr155_idle", 32'(vram_en), 32'd0);
    check("wr155_no_rvalid", 32'(cpu_rvalid), 32'd0);
    cyc();
    check("wr155_no_rvalid2", 32'(cpu_rvalid), 32'd0);

    // CPU write $0400 = 0xA5 then renderer read $0400, horizontal mirroring
    mirror_vert = 1'b0; cpu_valid = 1'b1; cpu_rw = 1'b0;
    cpu_addr = 12'h400; cpu_wdata = 8'hA5;
    cyc();
    cpu_valid = 1'b0;
    cyc();
    check("wr400_addr", 32'(vram_addr), 32'h000);
    rnd_valid = 1'b1; rnd_addr = 12'h400;
    cyc();
    rnd_valid = 1'b0;
    check("rd400_en", 32'(vram_en), 32'd1);
    check("rd400_rw", 32'(vram_rw), 32'd1);
    check("rd400_addr", 32'(vram_addr), 32'h000);
    check("rd400_early", 32'(rnd_rvalid), 32'd0);
    cyc();
    check("rd400_rvalid", 32'(rnd_rvalid), 32'd1);
    check("rd400_rdata", 32'(rnd_rdata), 32'hA5);
    cyc();
    check("rd400_rvalid_off", 32'(rnd_rvalid), 32'd0);
    check("rd400_hold", 32'(rnd_rdata), 32'hA5);

    // Renderer hogging: buffered CPU read must be forced through on cycle 5
    mirror_vert = 1'b1; rnd_valid = 1'b1; rnd_addr = 12'h123;
    cpu_valid = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h6AB;
    cyc();
    cpu_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("starve_rnd_ready_c%0d", k), 32'(rnd_ready), 32'(k != 5));
      cyc();
    end
    check("starve_gnt_en", 32'(vram_en), 32'd1);
    check("starve_gnt_addr", 32'(vram_addr), 32'h6AB);
    check("starve_rnd_ready_after", 32'(rnd_ready), 32'd1);
    rnd_valid = 1'b0;
    cyc();
    check("starve_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("starve_cpu_rdata", 32'(cpu_rdata), 32'(init_byte(12'h6AB)));
    cyc(); cyc();

    // Alternating CPU / renderer requests: the VRAM is busy every cycle
    for (int i = 0; i < 10; i++) begin
      cpu_valid = (i % 2 == 0); rnd_valid = (i % 2 == 1);
      cpu_rw = 1'b1; cpu_addr = 12'(16 * i + 1); rnd_addr = 12'(16 * i + 8);
      cyc();
      if (i >= 1) check($sformatf("alt_en_%0d", i), 32'(vram_en), 32'd1);
      if (i >= 2) check($sformatf("alt_one_owner_%0d", i), 32'(rnd_rvalid ^ cpu_rvalid), 32'd1);
    end
    cpu_valid = 1'b0; rnd_valid = 1'b0;
    cyc(); cyc(); cyc();

    // Reset in the middle of a CPU write grant
    mirror_vert = 1'b1; cpu_valid = 1'b1; cpu_rw = 1'b0;
    cpu_addr = 12'h333; cpu_wdata = 8'hEE;
    cyc();
    cpu_valid = 1'b0;
    cyc();
    check("midrst_en_before", 32'(vram_en), 32'd1);
    check("midrst_rw_before", 32'(vram_rw), 32'd0);
    rst_n = 1'b0;
    #1 reset_checks("midrst");
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    check("midrst_no_write", 32'(ram[11'h333]), 32'(init_byte(12'h333)));
    check("midrst_idle", 32'(vram_en), 32'd0);

    // Randomized traffic: balanced, renderer-heavy, CPU-heavy
    for (int j = 0; j < 1000; j++) begin
      if (j == 500) begin
        rst_n = 1'b0; rnd_valid = 1'b0; cpu_valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
      end
      rand_drive(50, 50);
      cyc();
    end
    for (int j = 0; j < 800; j++) begin
      rand_drive(95, 60);
      cyc();
    end
    for (int j = 0; j < 600; j++) begin
      rand_drive(20, 90);
      cyc();
    end
    rnd_valid = 1'b0; cpu_valid = 1'b0;
    cyc(); cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_vram_arbiter.md
PPU_VRAM_ARBITER -- requirements
Module: ppu_vram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles a pending CPU request may lose before it is forced through.
REQ-002 SHALL have ports: clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: mirror_vert  input  1  nametable mirroring; 1=vertical, 0=horizontal.
REQ-005 SHALL have ports: rnd_valid  input  1, rnd_ready  output  1, rnd_addr  input  12: renderer read request, nametable-space offset ($2000-relative).
REQ-006 SHALL have ports: rnd_rdata  output  8, rnd_rvalid  output  1: renderer read return.
REQ-007 SHALL have ports: cpu_valid  input  1, cpu_ready  output  1, cpu_rw  input  1 (1=read, 0=write), cpu_addr  input  12, cpu_wdata  input  8: CPU (PPUDATA) request.
REQ-008 SHALL have ports: cpu_rdata  output  8, cpu_rvalid  output  1: CPU read return.
REQ-009 SHALL have ports: vram_addr  output  11, vram_data_out  output  8, vram_en  output  1, vram_rw  output  1 (1=read, 0=write), vram_rdata  input  8: VRAM macro side; VRAM read data valid one cycle after the enabled cycle.

Function
REQ-010 SHALL transfer a request when valid and ready are both high at a rising edge; requester holds addr/data stable while valid and not ready.
REQ-011 SHALL hold one CPU request in a 1-entry buffer; cpu_ready = buffer empty; captured cpu_rw/addr/wdata stay in buffer until granted.
REQ-012 SHALL assert rnd_ready combinationally high except in a cycle where a forced CPU grant is pending (REQ-015).
REQ-013 SHALL arbitrate each cycle: accepted renderer request wins; otherwise buffered CPU request granted.
REQ-014 SHALL count, with a saturating counter, cycles a buffered CPU request is refused; counter clears on CPU grant.
REQ-015 SHALL, when counter equals STARVE_LIMIT, drive rnd_ready low next cycle and grant CPU regardless of rnd_valid.
REQ-016 SHALL register granted access onto vram_* in the cycle after the accepting/granting edge; vram_en high exactly one cycle per grant; vram_en low on idle cycles with vram_addr/data/rw holding last value.
REQ-017 SHALL map address: vertical -> vram_addr = {addr[10], addr[9:0]}; horizontal -> {addr[11], addr[9:0]}; mirror_vert sampled at grant edge.
REQ-018 SHALL tag each VRAM read with its owner and, one cycle after vram_en, pulse the owner's rvalid for one cycle with rdata = vram_rdata; total latency accept->rvalid = 2 cycles for renderer.
REQ-019 SHALL not assert any rvalid for CPU writes; rnd_rdata/cpu_rdata hold last returned value otherwise.
REQ-020 SHALL sustain one VRAM access per cycle (back-to-back grants, no bubble).
REQ-021 SHALL, on simultaneous CPU capture and CPU grant of the previous buffered entry, accept the new request (buffer frees and refills same edge; cpu_ready = empty OR granting).
REQ-022 SHALL implement FSM IDLE / RND_ACC / CPU_RD / CPU_WR encoding the registered VRAM cycle type; IDLE on no grant.

Reset
REQ-023 SHALL on rst_n low, asynchronously: vram_en=0, vram_rw=1, vram_addr=0, vram_data_out=0, rnd_rvalid=0, cpu_rvalid=0, rnd_rdata=0, cpu_rdata=0, buffer empty (cpu_ready=1), counter=0, FSM=IDLE, rnd_ready=1.
REQ-024 SHALL discard any in-flight access and pending rvalid when reset asserts mid-operation; no VRAM write issued after reset release without a new request.

Structure
REQ-025 SHALL place FSM state enum, owner tag type, and rw encoding constants (READ=1, WRITE=0) in shared package ppu_pkg.
REQ-026 SHALL implement mirroring as sub-module ppu_nt_mirror (12-bit addr + mirror_vert -> 11-bit addr), combinational.

Verification
REQ-027 SHALL cover: CPU write $0155=0x55 (vertical) -> vram_en=1, vram_rw=0, vram_addr=0x155, vram_data_out=0x55 one cycle after accept; no cpu_rvalid.
REQ-028 SHALL cover: renderer read $0400 after CPU write of 0xA5 to $0400, horizontal -> vram_addr=0x000; rnd_rvalid 2 cycles after accept, rnd_rdata=0xA5.
REQ-029 SHALL cover: rnd_valid held high continuously with CPU request buffered -> CPU granted on cycle 5 after buffering (STARVE_LIMIT=4), rnd_ready low exactly that cycle.
REQ-030 SHALL cover: alternating CPU/renderer valid every cycle -> vram_en high every cycle, each rvalid to correct owner, data in order.
REQ-031 SHALL cover: rst_n low mid CPU-write grant -> all outputs at reset values immediately; VRAM contents at that address unchanged.
